// File: rtl/router_pkg.sv
// Definitions shared by the packet arbiter and the routing demux: the header
// TID that opens a packet and the arbiter's two-state machine.
package router_pkg;

    localparam int ROUTING_HEADER = 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/axis_if.sv
// AXI4-Stream bundle with TID and TLAST; m drives a stream, s consumes it.
interface axis_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [ID_WIDTH-1:0]   tid;
    logic                  tlast;

    modport m (output tvalid, output tdata, output tid, output tlast, input tready);
    modport s (input tvalid, input tdata, input tid, input tlast, output tready);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first request found scanning upward from
// ptr+1 with wrap-around.
module rr_arbiter #(
    parameter int N = 5,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt_onehot,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_valid
);
    int cand;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_valid  = 1'b0;
        cand       = 0;
        // Walk from the farthest candidate to the nearest so the nearest one is written last.
        for (int k = N; k >= 1; k--) begin
            cand = (int'(ptr) + k) % N;
            if (req[cand]) begin
                gnt_onehot       = '0;
                gnt_onehot[cand] = 1'b1;
                gnt_idx          = W'(cand);
                gnt_valid        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin merge of CHANNEL_NUMBER AXI streams into one,
// holding a channel from its header beat to TLAST, with one output register.
module axis_packet_arbiter
    import router_pkg::*;
#(
    parameter int DATA_WIDTH           = 32,
    parameter int ID_WIDTH             = 4,
    parameter int CHANNEL_NUMBER       = 5,
    parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER)
) (
    input  logic                            clk,
    input  logic                            rst,
    axis_if.s                               in [CHANNEL_NUMBER],
    axis_if.m                               out,
    output logic [CHANNEL_NUMBER_WIDTH-1:0] grant,
    output logic                            locked
);
    localparam logic [ID_WIDTH-1:0]             HDR_ID  = ID_WIDTH'(ROUTING_HEADER);
    localparam logic [CHANNEL_NUMBER_WIDTH-1:0] LAST_CH = CHANNEL_NUMBER_WIDTH'(CHANNEL_NUMBER - 1);

    logic [CHANNEL_NUMBER-1:0] valid_vec;
    logic [CHANNEL_NUMBER-1:0] last_vec;
    logic [CHANNEL_NUMBER-1:0] hdr_req;
    logic [CHANNEL_NUMBER-1:0] ready_vec;
    logic [DATA_WIDTH-1:0]     data_arr [CHANNEL_NUMBER];
    logic [ID_WIDTH-1:0]       id_arr   [CHANNEL_NUMBER];

    generate
        for (genvar gi = 0; gi < CHANNEL_NUMBER; gi++) begin : g_chan
            assign valid_vec[gi]  = in[gi].tvalid;
            assign last_vec[gi]   = in[gi].tlast;
            assign data_arr[gi]   = in[gi].tdata;
            assign id_arr[gi]     = in[gi].tid;
            assign hdr_req[gi]    = in[gi].tvalid && (in[gi].tid == HDR_ID);
            assign in[gi].tready  = ready_vec[gi];
        end
    endgenerate

    arb_state_t                      state_reg, state_next;
    logic [CHANNEL_NUMBER_WIDTH-1:0] grant_reg, grant_next;
    logic [CHANNEL_NUMBER_WIDTH-1:0] last_grant_reg, last_grant_next;
    logic                            out_valid_reg;
    logic [DATA_WIDTH-1:0]           out_data_reg;
    logic [ID_WIDTH-1:0]             out_id_reg;
    logic                            out_last_reg;

    logic [CHANNEL_NUMBER-1:0]       arb_onehot;
    logic [CHANNEL_NUMBER_WIDTH-1:0] arb_idx;
    logic                            arb_valid;
    logic [CHANNEL_NUMBER_WIDTH-1:0] sel_idx;
    logic                            can_accept;
    logic                            accept;

    rr_arbiter #(
        .N (CHANNEL_NUMBER),
        .W (CHANNEL_NUMBER_WIDTH)
    ) u_rr (
        .req        (hdr_req),
        .ptr        (last_grant_reg),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx),
        .gnt_valid  (arb_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= LAST_CH;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        ready_vec       = '0;
        sel_idx         = grant_reg;
        can_accept      = !out_valid_reg || out.tready;
        // Reset also forces every TREADY low, not just the registered state.
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    sel_idx = arb_idx;
                    if (arb_valid && can_accept) ready_vec = arb_onehot;
                end
                LOCKED: begin
                    if (can_accept) ready_vec[grant_reg] = 1'b1;
                end
                default: ;
            endcase
        end
        accept = |(ready_vec & valid_vec);
        if (accept) begin
            case (state_reg)
                IDLE: begin
                    grant_next      = arb_idx;
                    last_grant_next = arb_idx;
                    state_next      = last_vec[sel_idx] ? IDLE : LOCKED;
                end
                LOCKED: begin
                    if (last_vec[sel_idx]) state_next = IDLE;
                end
                default: ;
            endcase
        end
    end

    // Payload only reloads on a new beat, so it holds while the sink stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_id_reg    <= '0;
            out_last_reg  <= 1'b0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= data_arr[sel_idx];
            out_id_reg    <= id_arr[sel_idx];
            out_last_reg  <= last_vec[sel_idx];
        end else if (out.tready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out.tvalid = out_valid_reg;
    assign out.tdata  = out_data_reg;
    assign out.tid    = out_id_reg;
    assign out.tlast  = out_last_reg;
    assign grant      = grant_reg;
    assign locked     = (state_reg == LOCKED);
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter: directed scenarios plus random traffic, checked
// each cycle against a cycle-level arbitration model and a per-source packet scoreboard.
module tb_axis_packet_arbiter;
    import router_pkg::*;

    localparam int NCH = 5;
    localparam logic [3:0] HDR = 4'(ROUTING_HEADER);

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  id;
        logic        last;
    } beat_t;

    logic clk;
    logic rst;
    logic [NCH-1:0] src_valid;
    logic [NCH-1:0] src_ready;
    logic [NCH-1:0] src_last;
    logic [31:0]    src_data [NCH];
    logic [3:0]     src_id   [NCH];
    logic           out_ready;
    logic [2:0]     grant;
    logic           locked;

    axis_if #(.DATA_WIDTH(32), .ID_WIDTH(4)) in_if [NCH] ();
    axis_if #(.DATA_WIDTH(32), .ID_WIDTH(4)) out_if ();

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_src
            assign in_if[gi].tvalid = src_valid[gi];
            assign in_if[gi].tdata  = src_data[gi];
            assign in_if[gi].tid    = src_id[gi];
            assign in_if[gi].tlast  = src_last[gi];
            assign src_ready[gi]    = in_if[gi].tready;
        end
    endgenerate
    assign out_if.tready = out_ready;

    axis_packet_arbiter #(
        .DATA_WIDTH     (32),
        .ID_WIDTH       (4),
        .CHANNEL_NUMBER (NCH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .in     (in_if),
        .out    (out_if),
        .grant  (grant),
        .locked (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    beat_t srcq [NCH][$];
    beat_t expq [NCH][$];
    logic [31:0] out_log[$];
    logic [31:0] exp_log[$];
    logic [NCH-1:0] hs_vec;
    int gap_pct, ready_pct, stall_cnt;
    int first_hs [NCH];
    int last_tlast [NCH];
    int hs_cnt [NCH];
    int first_ov, sb_ch, pushed, delivered;
    bit m_locked, m_ov;
    int m_grant, m_last;
    beat_t m_beat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic clear_marks();
        for (int c = 0; c < NCH; c++) begin
            first_hs[c] = -1; last_tlast[c] = -1; hs_cnt[c] = 0;
        end
        first_ov = -1;
        out_log.delete();
    endtask

    task automatic check_cycle();
        logic [NCH-1:0] exp_rdy;
        beat_t b;
        int win, a, c;
        bit can, ok;
        cyc++;
        if (rst) begin
            chk("rst_tready", 64'(src_ready), 64'(0));
            chk("rst_tvalid", 64'(out_if.tvalid), 64'(0));
            chk("rst_payload", {27'd0, out_if.tdata, out_if.tid, out_if.tlast}, 64'(0));
            chk("rst_locked", 64'(locked), 64'(0));
            chk("rst_grant", 64'(grant), 64'(0));
            m_locked = 0; m_ov = 0; m_grant = 0; m_last = NCH - 1;
            sb_ch = -1; hs_vec = '0;
            return;
        end
        // Expected TREADY straight from the arbitration rules.
        can = !m_ov || out_ready;
        exp_rdy = '0;
        if (!m_locked) begin
            win = -1;
            for (int k = 1; k <= NCH && win < 0; k++) begin
                c = (m_last + k) % NCH;
                if (src_valid[c] && src_id[c] == HDR) win = c;
            end
            if (win >= 0 && can) exp_rdy[win] = 1'b1;
        end else if (can) begin
            exp_rdy[m_grant] = 1'b1;
        end
        chk("tready", 64'(src_ready), 64'(exp_rdy));
        chk("out_tvalid", 64'(out_if.tvalid), 64'(m_ov));
        chk("locked", 64'(locked), 64'(m_locked));
        chk("grant", 64'(grant), 64'(m_grant));
        if (m_ov) chk("out_payload", {27'd0, out_if.tdata, out_if.tid, out_if.tlast}, 64'(m_beat));
        if (out_if.tvalid && first_ov < 0) first_ov = cyc;

        // Packet scoreboard: each output beat is the next beat of one source, packets contiguous.
        if (out_if.tvalid && out_ready) begin
            b.d = out_if.tdata; b.id = out_if.tid; b.last = out_if.tlast;
            a = sb_ch;
            if (a < 0)
                for (int k = 0; k < NCH; k++)
                    if (a < 0 && expq[k].size() > 0 && expq[k][0] == b) a = k;
            ok = (a >= 0) && (expq[a].size() > 0) && (expq[a][0] == b);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL scoreboard cyc=%0d actual=%08h required=next beat of ch%0d", cyc, b.d, sb_ch);
            end else begin
                expq[a].delete(0);
                sb_ch = b.last ? -1 : a;
            end
            out_log.push_back(b.d);
            delivered++;
            $display("beat cyc=%0d ch%0d data=%08h id=%0h last=%0b", cyc, a, b.d, b.id, b.last);
        end

        hs_vec = src_valid & src_ready;
        for (int k = 0; k < NCH; k++) begin
            if (hs_vec[k]) begin
                if (first_hs[k] < 0) first_hs[k] = cyc;
                if (src_last[k]) last_tlast[k] = cyc;
                hs_cnt[k]++;
            end
        end

        if (m_ov && out_ready) m_ov = 0;
        a = -1;
        for (int k = 0; k < NCH; k++) if (exp_rdy[k] && src_valid[k]) a = k;
        if (a >= 0) begin
            m_ov = 1;
            m_beat.d = src_data[a]; m_beat.id = src_id[a]; m_beat.last = src_last[a];
            if (!m_locked) begin
                m_grant = a; m_last = a; m_locked = !src_last[a];
            end else if (src_last[a]) begin
                m_locked = 0;
            end
        end
    endtask

    task automatic drive();
        for (int c = 0; c < NCH; c++) begin
            if (hs_vec[c] && srcq[c].size() > 0) begin
                srcq[c].delete(0);
                src_valid[c] = 1'b0;
            end
            if (srcq[c].size() == 0) begin
                src_valid[c] = 1'b0;
            end else begin
                if (!src_valid[c]) src_valid[c] = (int'($urandom_range(99)) >= gap_pct);
                src_data[c] = srcq[c][0].d;
                src_id[c]   = srcq[c][0].id;
                src_last[c] = srcq[c][0].last;
            end
        end
        hs_vec = '0;
        if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
        end else begin
            out_ready = (int'($urandom_range(99)) < ready_pct);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic push_beat(input int c, input beat_t b, input bit expect_out);
        srcq[c].push_back(b);
        if (expect_out) expq[c].push_back(b);
    endtask

    task automatic push_pkt(input int c, input int len, input logic [31:0] base);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = base + 32'(i);
            b.id = (i == 0) ? HDR : 4'h2;
            b.last = (i == len - 1);
            push_beat(c, b, 1'b1);
        end
    endtask

    task automatic push_rand(input int c);
        beat_t b;
        int len;
        len = int'($urandom_range(5, 1));
        for (int i = 0; i < len; i++) begin
            b.d = $urandom;
            b.id = (i == 0) ? HDR : 4'($urandom_range(15));
            b.last = (i == len - 1);
            push_beat(c, b, 1'b1);
            pushed++;
        end
    endtask

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int c = 0; c < NCH; c++) if (srcq[c].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((!all_empty() || out_if.tvalid) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout actual=%0d cycles required=drained", name, n);
        end
    endtask

    task automatic wait_hs(input int c, input int count, input int budget);
        int n;
        n = 0;
        while (hs_cnt[c] < count && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_hs_ch%0d actual=%0d required=%0d", c, hs_cnt[c], count);
        end
    endtask

    task automatic chk_log(input string name);
        chk({name, "_len"}, 64'(out_log.size()), 64'(exp_log.size()));
        for (int i = 0; i < out_log.size() && i < exp_log.size(); i++)
            chk(name, 64'(out_log[i]), 64'(exp_log[i]));
    endtask

    initial begin
        int total;
        rst = 1'b1; src_valid = '0; src_last = '0; out_ready = 1'b1;
        for (int c = 0; c < NCH; c++) begin src_data[c] = '0; src_id[c] = '0; end
        gap_pct = 0; ready_pct = 100; stall_cnt = 0; hs_vec = '0;
        sb_ch = -1; pushed = 0; delivered = 0;
        clear_marks();
        repeat (3) step();
        rst = 1'b0;
        step();

        // Simultaneous headers on ch1 and ch3 right after reset.
        clear_marks();
        push_pkt(1, 3, 32'h100);
        push_pkt(3, 3, 32'h300);
        wait_drain("t29", 100);
        exp_log = {32'h100, 32'h101, 32'h102, 32'h300, 32'h301, 32'h302};
        chk_log("t29_order");
        chk("t29_latency", 64'(first_ov), 64'(first_hs[1] + 1));

        // ch0 header arrives while ch2 is mid-packet.
        clear_marks();
        push_pkt(2, 4, 32'h200);
        wait_hs(2, 2, 50);
        push_pkt(0, 2, 32'h010);
        wait_drain("t30", 100);
        exp_log = {32'h200, 32'h201, 32'h202, 32'h203, 32'h010, 32'h011};
        chk_log("t30_order");
        chk("t30_ch0_after_tlast", 64'(first_hs[0]), 64'(last_tlast[2] + 1));

        // Sink stalls three cycles in the middle of a packet.
        clear_marks();
        push_pkt(1, 4, 32'h0A0);
        for (int n = 0; n < 50 && out_log.size() < 2; n++) step();
        stall_cnt = 3;
        wait_drain("t31", 100);
        exp_log = {32'h0A0, 32'h0A1, 32'h0A2, 32'h0A3};
        chk_log("t31_seq");

        // Single-beat packet on ch4, then ch0 must win over ch3.
        clear_marks();
        push_pkt(4, 1, 32'h400);
        wait_drain("t32a", 100);
        chk("t32_grant", 64'(grant), 64'(4));
        chk("t32_locked", 64'(locked), 64'(0));
        clear_marks();
        push_pkt(3, 2, 32'h330);
        push_pkt(0, 2, 32'h030);
        wait_drain("t32b", 100);
        exp_log = {32'h030, 32'h031, 32'h330, 32'h331};
        chk_log("t32_rr_from_ch0");

        // A stray non-header beat in IDLE is never accepted.
        clear_marks();
        push_beat(1, '{d: 32'h55, id: 4'h2, last: 1'b0}, 1'b0);
        repeat (10) step();
        chk("t33_pending", 64'(srcq[1].size()), 64'(1));
        chk("t33_no_output", 64'(out_log.size()), 64'(0));
        chk("t33_tready", 64'(src_ready[1]), 64'(0));
        srcq[1].delete();
        step();

        // Reset pulsed during beat 2 of a ch3 packet.
        clear_marks();
        push_pkt(3, 4, 32'h3A0);
        wait_hs(3, 2, 50);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t34_tvalid", 64'(out_if.tvalid), 64'(0));
        chk("t34_locked", 64'(locked), 64'(0));
        chk("t34_grant", 64'(grant), 64'(0));
        chk("t34_tready", 64'(src_ready), 64'(0));
        for (int c = 0; c < NCH; c++) begin srcq[c].delete(); expq[c].delete(); end
        step();

        // Random traffic with gaps and back-pressure.
        gap_pct = 25; ready_pct = 70; pushed = 0; delivered = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(99) < 30) begin
                int c;
                c = int'($urandom_range(NCH - 1));
                if (srcq[c].size() < 10) push_rand(c);
            end
            step();
        end
        wait_drain("rand", 3000);
        step();
        total = 0;
        for (int c = 0; c < NCH; c++) total += expq[c].size();
        chk("rand_delivered", 64'(delivered), 64'(pushed));
        chk("rand_leftover", 64'(total), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_packet_arbiter.md
AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: TDATA width in bits.
REQ-002 SHALL have parameter ID_WIDTH, default 4: TID width in bits.
REQ-003 SHALL have parameter CHANNEL_NUMBER, default 5: number of input channels.
REQ-004 SHALL have parameter CHANNEL_NUMBER_WIDTH, default $clog2(CHANNEL_NUMBER): grant index width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port in, axis_if.s array [CHANNEL_NUMBER]: candidate input streams carrying TVALID, TREADY, TDATA, TID and TLAST.
REQ-008 SHALL have port out, axis_if.m: the merged output stream.
REQ-009 SHALL have port grant, output, CHANNEL_NUMBER_WIDTH bits: index of the current or last granted channel.
REQ-010 SHALL have port locked, output, 1 bit: high while a packet is in progress.

Function
REQ-011 SHALL treat a packet as a header beat (TID == ROUTING_HEADER) followed by beats up to and including the beat with TLAST=1.
REQ-012 SHALL implement two states: IDLE and LOCKED.
REQ-013 In IDLE, SHALL select among channels whose TVALID=1 and TID=ROUTING_HEADER using round-robin, scanning from (last_grant+1) mod CHANNEL_NUMBER upward with wrap-around.
REQ-014 In IDLE, SHALL hold TREADY=0 on every channel presenting a non-header beat or not selected; such beats stall and are not dropped.
REQ-015 SHALL, on handshake of the selected header beat, set grant to that channel and enter LOCKED, or stay IDLE if that beat has TLAST=1; last_grant SHALL update in both cases.
REQ-016 In LOCKED, only in[grant].TREADY SHALL be allowed to be 1; all other TREADY SHALL be 0 regardless of their TVALID/TID.
REQ-017 In LOCKED, a granted beat with TID=ROUTING_HEADER SHALL be forwarded as ordinary payload.
REQ-018 In LOCKED, a handshake on the granted channel with TLAST=1 SHALL return the state to IDLE in the next cycle; the next arbitration SHALL start in that IDLE cycle.
REQ-019 SHALL register the output in one pipeline stage: a beat accepted at cycle N SHALL appear on out at cycle N+1; out.TDATA/TID/TLAST SHALL be copied unmodified.
REQ-020 in[g].TREADY SHALL equal (!out.TVALID || out.TREADY) gated by the arbitration rules, giving 1 beat/cycle sustained throughput.
REQ-021 While out.TVALID=1 and out.TREADY=0, out payload SHALL hold stable.
REQ-022 SHALL clear out.TVALID after a handshake when no new beat is accepted in the same cycle.
REQ-023 Gaps (TVALID=0) inside a locked packet SHALL keep LOCKED and grant unchanged.
REQ-024 TREADY SHALL NOT depend combinationally on the TVALID of the same channel, except through selection among headers in IDLE.

Reset
REQ-025 While rst=1: state=IDLE; locked=0; out.TVALID=0; out.TDATA, out.TID and out.TLAST=0; all in[].TREADY=0; grant=0; last_grant=CHANNEL_NUMBER-1, so channel 0 wins first.
REQ-026 Reset asserted mid-packet SHALL discard the registered beat and the lock; no partial-packet recovery.

Structure
REQ-027 ROUTING_HEADER and the state enum SHALL be defined in the shared router package, imported by this block and by the routing demux.
REQ-028 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, pointer, one-hot grant and index, valid); pipeline stage and FSM stay in axis_packet_arbiter.

Verification
REQ-029 Channels 1 and 3 present headers simultaneously after reset, 3-beat packets -> ch1 granted first, 3 beats out with latency 1, then ch3.
REQ-030 Ch2 in mid-packet (beat 2 of 4) while ch0 presents a header -> ch0 TREADY=0 until ch2 TLAST handshake; ch0 granted in the following cycle.
REQ-031 out.TREADY held 0 for 3 cycles mid-packet -> out payload stable, no beat lost or duplicated, sequence 0xA0..0xA3 intact.
REQ-032 Single-beat packet (header with TLAST=1) on ch4 -> locked stays 0, grant=4, next arbitration starts from ch0.
REQ-033 Non-header beat on ch1 in IDLE -> TREADY=0 indefinitely, out.TVALID stays 0.
REQ-034 rst pulsed during beat 2 of a ch3 packet -> next cycle out.TVALID=0, locked=0, grant=0, all TREADY=0.
